sonic_vc_tx_fifo_p0_width_adapter: RTL and testbench

SONIC_VC_TX_FIFO_P0_WIDTH_ADAPTER -- requirements
Module: sonic_vc_tx_fifo_p0_width_adapter

---
 rtl/sonic_vc_tx_fifo_p0_width_adapter.sv | 129 ++++++++++++
 tb/tb_sonic_vc_tx_fifo_p0_width_adapter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_vc_tx_fifo_p0_width_adapter.sv
// Splits 133-bit FIFO words into 64-bit beats. Upper half goes first.
// Short eop words (8 or more empty bytes) are sent as a single beat.
module sonic_vc_tx_fifo_p0_width_adapter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [132:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [2:0]           out_empty,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  typedef enum logic {
    HALF_HI = 1'b0,
    HALF_LO = 1'b1
  } half_e;

  logic [132:0]         hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  half_e                half_q, half_d;
  logic                 sop_pending_q, sop_pending_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

  logic       is_short_s;
  logic       last_beat_s;
  logic       in_xfer_s;
  logic       out_xfer_s;
  logic       beat_eop_s;
  logic [2:0] beat_empty_s;
  logic [3:0] short_empty_s;

  // Beat flags for the half currently presented
  always_comb begin
    is_short_s    = hold_q[132] && (hold_q[131:128] >= 4'd8);
    short_empty_s = hold_q[131:128] - 4'd8;
    last_beat_s   = (half_q == HALF_LO) || is_short_s;
    beat_eop_s    = 1'b0;
    beat_empty_s  = 3'd0;
    case (half_q)
      HALF_HI: begin
        beat_eop_s   = is_short_s;
        beat_empty_s = is_short_s ? short_empty_s[2:0] : 3'd0;
      end
      HALF_LO: begin
        beat_eop_s   = hold_q[132];
        beat_empty_s = hold_q[132] ? hold_q[130:128] : 3'd0;
      end
      default: begin
        beat_eop_s   = 1'b0;
        beat_empty_s = 3'd0;
      end
    endcase
  end

  // A new word may enter on the same edge that retires the last beat
  always_comb begin
    in_ready   = !hold_valid_q || (out_ready && last_beat_s);
    in_xfer_s  = in_valid && in_ready;
    out_xfer_s = hold_valid_q && out_ready;
  end

  // Next-state for the holding register, half select, sop and counter
  always_comb begin
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    half_d        = half_q;
    sop_pending_d = sop_pending_q;
    pkt_count_d   = pkt_count_q;

    if (in_xfer_s) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
      half_d       = HALF_HI;
    end else if (out_xfer_s) begin
      if (last_beat_s) begin
        hold_valid_d = 1'b0;
      end else begin
        half_d = HALF_LO;
      end
    end else begin
      hold_valid_d = hold_valid_q;
    end

    // A short eop word is both HI and eop; eop wins so the next word opens a packet
    if (out_xfer_s && beat_eop_s) begin
      sop_pending_d = 1'b1;
      pkt_count_d   = pkt_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (out_xfer_s && (half_q == HALF_HI)) begin
      sop_pending_d = 1'b0;
    end else begin
      sop_pending_d = sop_pending_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q        <= 133'd0;
      hold_valid_q  <= 1'b0;
      half_q        <= HALF_HI;
      sop_pending_q <= 1'b1;
      pkt_count_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      half_q        <= half_d;
      sop_pending_q <= sop_pending_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  // Output decode from registered state only
  always_comb begin
    out_valid = hold_valid_q;
    out_data  = (half_q == HALF_HI) ? hold_q[127:64] : hold_q[63:0];
    out_sop   = hold_valid_q && (half_q == HALF_HI) && sop_pending_q;
    out_eop   = hold_valid_q && beat_eop_s;
    out_empty = hold_valid_q ? beat_empty_s : 3'd0;
    pkt_count = pkt_count_q;
  end

endmodule

// File: tb/tb_sonic_vc_tx_fifo_p0_width_adapter.sv
// Scoreboard bench for the 133->64 width adapter; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_sonic_vc_tx_fifo_p0_width_adapter;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [132:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_sop;
  logic         out_eop;
  logic [2:0]   out_empty;
  logic [15:0]  pkt_count;

  logic         in_ready4;
  logic         out_valid4;
  logic [63:0]  out_data4;
  logic         out_sop4;
  logic         out_eop4;
  logic [2:0]   out_empty4;
  logic [3:0]   pkt_count4;

  beat_t       exp_q[$];
  beat_t       mon_b;
  logic        sop_exp;
  logic [31:0] exp_pkt;
  int          checks;
  int          failures;
  int          cycles;
  bit          done;

  sonic_vc_tx_fifo_p0_width_adapter dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .pkt_count(pkt_count)
  );

  sonic_vc_tx_fifo_p0_width_adapter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_sop(out_sop4), .out_eop(out_eop4),
    .out_empty(out_empty4), .pkt_count(pkt_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [132:0] mk(input logic [127:0] d, input logic eop, input logic [3:0] e);
    return {eop, e, d};
  endfunction

  // Reference model: expected beats of one accepted word
  function automatic void push_word(input logic [132:0] w);
    beat_t      b;
    logic [3:0] e;
    logic [3:0] e8;
    e  = w[131:128];
    e8 = e - 4'd8;
    if (w[132] && (e >= 4'd8)) begin
      b = '{data: w[127:64], sop: sop_exp, eop: 1'b1, empty: e8[2:0]};
      exp_q.push_back(b);
      sop_exp = 1'b1;
      exp_pkt = exp_pkt + 32'd1;
    end else begin
      b = '{data: w[127:64], sop: sop_exp, eop: 1'b0, empty: 3'd0};
      exp_q.push_back(b);
      sop_exp = 1'b0;
      b = '{data: w[63:0], sop: 1'b0, eop: w[132], empty: (w[132] ? e[2:0] : 3'd0)};
      exp_q.push_back(b);
      if (w[132]) begin
        sop_exp = 1'b1;
        exp_pkt = exp_pkt + 32'd1;
      end
    end
  endfunction

  // Output monitor: pop and compare every accepted beat
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got data=%h sop=%b eop=%b empty=%0d, none expected",
                 out_data, out_sop, out_eop, out_empty);
      end else begin
        mon_b = exp_q.pop_front();
        if ({out_data, out_sop, out_eop, out_empty} !== mon_b) begin
          failures++;
          $display("FAIL beat: got data=%h sop=%b eop=%b empty=%0d, expected data=%h sop=%b eop=%b empty=%0d",
                   out_data, out_sop, out_eop, out_empty, mon_b.data, mon_b.sop, mon_b.eop, mon_b.empty);
        end
      end
    end
    if (reset_n) begin
      checks++;
      if ({out_valid4, out_data4, out_sop4, out_eop4, out_empty4, in_ready4} !==
          {out_valid, out_data, out_sop, out_eop, out_empty, in_ready}) begin
        failures++;
        $display("FAIL dut4_lockstep: got v=%b d=%h, expected v=%b d=%h", out_valid4, out_data4, out_valid, out_data);
      end
    end
  end

  task automatic do_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = 133'd0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    sop_exp = 1'b1;
    exp_pkt = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [132:0] w);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: in_ready got 0 for 500 cycles, expected 1");
    end else begin
      push_word(w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {5'($urandom), $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 133'd0;
    #3;
    checks++;
    if ({out_valid, in_ready, pkt_count, pkt_count4} !== {1'b1 ^ 1'b1, 1'b1, 16'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_state: got valid=%b ready=%b cnt=%0d cnt4=%0d, expected 0 1 0 0",
               out_valid, in_ready, pkt_count, pkt_count4);
    end
    do_reset();
  endtask

  task automatic test_two_beat;
    out_ready = 1'b1;
    send_word(mk(128'h00112233445566778899AABBCCDDEEFF, 1'b0, 4'd0));
    @(negedge clk);
    checks++;
    if ({out_valid, out_sop, out_data, in_ready} !== {1'b1, 1'b1, 64'h0011223344556677, 1'b0}) begin
      failures++;
      $display("FAIL two_beat_hi: got v=%b sop=%b d=%h rdy=%b, expected 1 1 0011223344556677 0",
               out_valid, out_sop, out_data, in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_sop, out_eop, out_data, in_ready} !== {1'b0, 1'b0, 64'h8899AABBCCDDEEFF, 1'b1}) begin
      failures++;
      $display("FAIL two_beat_lo: got sop=%b eop=%b d=%h rdy=%b, expected 0 0 8899aabbccddeeff 1",
               out_sop, out_eop, out_data, in_ready);
    end
    wait_drain();
  endtask

  task automatic test_long_eop;
    send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd5));
    @(negedge clk);
    checks++;
    if ({out_eop, out_empty, in_ready} !== {1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL long_eop_hi: got eop=%b empty=%0d rdy=%b, expected 0 0 0", out_eop, out_empty, in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_eop, out_empty} !== {1'b1, 3'd5}) begin
      failures++;
      $display("FAIL long_eop_lo: got eop=%b empty=%0d, expected 1 5", out_eop, out_empty);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL long_eop_cnt: got %0d, expected 1", pkt_count);
    end
  endtask

  task automatic test_short_eop;
    send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd12));
    @(negedge clk);
    checks++;
    if ({out_valid, out_eop, out_empty, in_ready} !== {1'b1, 1'b1, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL short_eop: got v=%b eop=%b empty=%0d rdy=%b, expected 1 1 4 1",
               out_valid, out_eop, out_empty, in_ready);
    end
    @(posedge clk);
    #1;
    send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd9));
    @(negedge clk);
    checks++;
    if (out_sop !== 1'b1) begin
      failures++;
      $display("FAIL short_eop_next_sop: got %b, expected 1", out_sop);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back;
    int c0;
    out_ready = 1'b1;
    c0 = cycles;
    for (int i = 0; i < 8; i++) send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'(8 + i)));
    checks++;
    if (cycles - c0 !== 8) begin
      failures++;
      $display("FAIL b2b_short: got %0d cycles, expected 8", cycles - c0);
    end
    c0 = cycles;
    for (int i = 0; i < 4; i++) send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'(i == 3), 4'd2));
    checks++;
    if (cycles - c0 !== 7) begin
      failures++;
      $display("FAIL b2b_long: got %0d cycles, expected 7", cycles - c0);
    end
    wait_drain();
  endtask

  task automatic test_backpressure;
    logic [132:0] w;
    w = mk({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd7);
    out_ready = 1'b1;
    send_word(w);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {5'($urandom), $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_sop, out_eop, out_empty, in_ready} !== {1'b1, w[63:0], 1'b0, 1'b0, 3'd0, 1'b0}) begin
        failures++;
        $display("FAIL backpressure_hold: got v=%b d=%h rdy=%b, expected 1 %h 0",
                 out_valid, out_data, in_ready, w[63:0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_random;
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          int nw;
          nw = $urandom_range(1, 9);
          for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'(i == nw - 1), 4'($urandom_range(0, 15))));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    checks++;
    if ({pkt_count, pkt_count4} !== {16'd200, 4'd8}) begin
      failures++;
      $display("FAIL random_cnt: got %0d/%0d, expected 200/8", pkt_count, pkt_count4);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 17; i++) send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd15));
    wait_drain();
    checks++;
    if ({pkt_count, pkt_count4} !== {16'd17, 4'd1}) begin
      failures++;
      $display("FAIL wrap_cnt: got %0d/%0d, expected 17/1", pkt_count, pkt_count4);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, pkt_count} !== {1'b0, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL reset_mid: got v=%b rdy=%b cnt=%0d, expected 0 1 0", out_valid, in_ready, pkt_count);
    end
    exp_q.delete();
    sop_exp = 1'b1;
    exp_pkt = 32'd0;
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_word(mk({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd3));
    @(negedge clk);
    checks++;
    if (out_sop !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_sop: got %b, expected 1", out_sop);
    end
    wait_drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cycles   = 0;
    done     = 1'b0;
    sop_exp  = 1'b1;
    exp_pkt  = 32'd0;
    test_reset();
    test_two_beat();
    test_long_eop();
    test_short_eop();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d beats outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
